// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and encodings for the MEM-stage access controller
package mem_pkg;

  // Controller states: idle, one byte per cycle, completion cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BYTES  = WORD_W / 8;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Counter width able to index every byte of a DATA_W word
  function automatic int cnt_width(input int data_w);
    int n;
    n = data_w / 8;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_lane_shift.sv
// rtl/mem_lane_shift.sv - big-endian read assembly and write byte-lane select
module mem_lane_shift
  import mem_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int CNT_W  = cnt_width(WORD_W)
) (
  input  logic              clk,
  input  logic              R,
  input  logic              i_clr,
  input  logic              i_shift_en,
  input  logic [7:0]        i_byte,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_size,
  input  logic [CNT_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_rdata,
  output logic [7:0]        o_wr_byte
);

  localparam int LBYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_shift;

  // Read bytes arrive most-significant first, so each new byte enters at the bottom
  always_ff @(posedge clk) begin
    if (R) begin
      r_shift <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
    end else if (i_shift_en) begin
      r_shift <= (r_shift << 8) | DATA_W'(i_byte);
    end
  end

  assign o_rdata = r_shift;

  // Word stores emit the top byte at index 0; byte stores always use the low byte
  always_comb begin
    o_wr_byte = i_wdata[7:0];
    if (i_size == SIZE_WORD) begin
      for (int i = 0; i < LBYTES; i++) begin
        if (i_idx == CNT_W'(LBYTES - 1 - i)) begin
          o_wr_byte = i_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer for a byte-wide data RAM
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              R,
  input  logic              req,
  input  logic              rw,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_e,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do
);

  localparam int LBYTES = DATA_W / 8;
  localparam int CNT_W  = cnt_width(DATA_W);
  // Word accesses clear the in-word offset bits; assumes a power-of-two byte count
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(LBYTES - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_rw;
  logic                r_size;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_start;
  logic                w_last_byte;
  logic                w_shift_en;
  logic [7:0]          w_lane;
  logic [DATA_W-1:0]   w_rdata;

  assign w_start     = (r_state == IDLE) && req;
  assign w_last_byte = (r_cnt == r_last);
  assign w_shift_en  = (r_state == XFER) && (r_rw == RW_READ);

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: RESP always returns to IDLE so a held req is not seen twice
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = XFER;
      XFER:    if (w_last_byte) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture in IDLE and byte counter advance during XFER
  always_ff @(posedge clk) begin
    if (R) begin
      r_rw    <= RW_READ;
      r_size  <= SIZE_BYTE;
      r_base  <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_rw    <= rw;
      r_size  <= size;
      r_base  <= (size == SIZE_WORD) ? (addr & ~ALIGN_MASK) : addr;
      r_cnt   <= '0;
      r_last  <= (size == SIZE_WORD) ? CNT_W'(LBYTES - 1) : '0;
      r_wdata <= wdata;
    end else if ((r_state == XFER) && !w_last_byte) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  mem_lane_shift #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lane (
    .clk        (clk),
    .R          (R),
    .i_clr      (w_start),
    .i_shift_en (w_shift_en),
    .i_byte     (ram_do),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_idx      (r_cnt),
    .o_rdata    (w_rdata),
    .o_wr_byte  (w_lane)
  );

  assign rdata = w_rdata;

  // Outputs; R masks everything so no RAM write or stall escapes during reset
  always_comb begin
    stall    = 1'b0;
    done     = 1'b0;
    ram_e    = 1'b0;
    ram_rw   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (!R) begin
      case (r_state)
        IDLE: stall = req;
        XFER: begin
          stall    = 1'b1;
          ram_e    = 1'b1;
          ram_rw   = r_rw;
          ram_addr = r_base + ADDR_W'(r_cnt);
          ram_di   = (r_rw == RW_WRITE) ? w_lane : 8'h00;
        end
        RESP: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        R;
  logic        req;
  logic        rw;
  logic        size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        ram_e;
  logic        ram_rw;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;

  logic [7:0]  mem [256];
  int          n_vec = 0;
  int          n_err = 0;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk      (clk),
    .R        (R),
    .req      (req),
    .rw       (rw),
    .size     (size),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .done     (done),
    .rdata    (rdata),
    .ram_e    (ram_e),
    .ram_rw   (ram_rw),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_e && ram_rw) mem[ram_addr] <= ram_di;
  end
  assign ram_do = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ms_bytes [4];
  logic [7:0] ms_addrs [4];

  initial begin
    ms_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ms_addrs = '{8'h34, 8'h35, 8'h36, 8'h37};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[52] = 8'h80; mem[53] = 8'h00; mem[54] = 8'h00; mem[55] = 8'h07;
    mem[56] = 8'h09; mem[57] = 8'h03;
    mem[8'h42] = 8'hA5; mem[8'h43] = 8'h5C;

    // reset held two edges with a request pending
    R = 1'b1; req = 1'b1; rw = 1'b1; size = 1'b1; addr = 8'h10; wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_stall", stall, 0);
      chk("rst_done",  done,  0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ram_e", ram_e, 0);
    end
    R = 1'b0; req = 1'b0; #1;
    chk("idle_stall", stall, 0);

    // byte store 0x5A to 58
    req = 1'b1; rw = 1'b1; size = 1'b0; addr = 8'd58; wdata = 32'h0000_005A; #1;
    chk("bs_t0_stall", stall, 1);
    chk("bs_t0_ram_e", ram_e, 0);
    tick();
    addr = 8'd0; wdata = 32'hFFFF_FFFF; #1;
    chk("bs_t1_stall", stall, 1);
    chk("bs_t1_ram_e", ram_e, 1);
    chk("bs_t1_rw",    ram_rw, 1);
    chk("bs_t1_addr",  ram_addr, 58);
    chk("bs_t1_di",    ram_di, 32'h5A);
    chk("bs_t1_done",  done, 0);
    tick();
    chk("bs_t2_done",  done, 1);
    chk("bs_t2_stall", stall, 0);
    chk("bs_t2_ram_e", ram_e, 0);
    chk("bs_t2_rdata", rdata, 0);
    req = 1'b0;
    tick();
    chk("bs_t3_done",  done, 0);
    chk("bs_t3_stall", stall, 0);
    chk("bs_mem58",    mem[58], 32'h5A);

    // word load from 52
    req = 1'b1; rw = 1'b0; size = 1'b1; addr = 8'd52; #1;
    chk("wl_t0_stall", stall, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wl_ram_e",  ram_e, 1);
      chk("wl_rw",     ram_rw, 0);
      chk("wl_addr",   ram_addr, 52 + k);
      chk("wl_stall",  stall, 1);
      chk("wl_done",   done, 0);
    end
    tick();
    chk("wl_t5_done",  done, 1);
    chk("wl_t5_stall", stall, 0);
    chk("wl_t5_rdata", rdata, 32'h8000_0007);
    req = 1'b0;
    tick();
    chk("wl_t6_done",  done, 0);
    chk("wl_t6_rdata", rdata, 32'h8000_0007);

    // misaligned word store to 0x35 lands at 0x34
    req = 1'b1; rw = 1'b1; size = 1'b1; addr = 8'h35; wdata = 32'hDEAD_BEEF; #1;
    chk("ms_t0_stall", stall, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ms_addr", ram_addr, ms_addrs[k]);
      chk("ms_di",   ram_di, ms_bytes[k]);
      chk("ms_rw",   ram_rw, 1);
    end
    tick();
    chk("ms_done",  done, 1);
    chk("ms_rdata", rdata, 0);
    req = 1'b0;
    tick();
    chk("ms_mem34", mem[8'h34], 32'hDE);
    chk("ms_mem35", mem[8'h35], 32'hAD);
    chk("ms_mem36", mem[8'h36], 32'hBE);
    chk("ms_mem37", mem[8'h37], 32'hEF);

    // word load from 0x36 reads the aligned word back
    req = 1'b1; rw = 1'b0; size = 1'b1; addr = 8'h36; #1;
    tick();
    chk("ml_addr0", ram_addr, 8'h34);
    for (int k = 0; k < 4; k++) tick();
    chk("ml_done",  done, 1);
    chk("ml_rdata", rdata, 32'hDEAD_BEEF);
    req = 1'b0;
    tick();

    // reset during the third XFER cycle of a word store
    req = 1'b1; rw = 1'b1; size = 1'b1; addr = 8'h40; wdata = 32'h1122_3344; #1;
    tick();
    chk("rm_addr0", ram_addr, 8'h40);
    chk("rm_di0",   ram_di, 32'h11);
    tick();
    chk("rm_addr1", ram_addr, 8'h41);
    chk("rm_di1",   ram_di, 32'h22);
    tick();
    R = 1'b1; #1;
    chk("rm_r_ram_e", ram_e, 0);
    chk("rm_r_stall", stall, 0);
    tick();
    R = 1'b0; req = 1'b0; #1;
    chk("rm_post_ram_e", ram_e, 0);
    chk("rm_post_stall", stall, 0);
    chk("rm_post_done",  done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rm_no_done", done, 0);
      chk("rm_idle_e",  ram_e, 0);
    end
    chk("rm_mem40", mem[8'h40], 32'h11);
    chk("rm_mem41", mem[8'h41], 32'h22);
    chk("rm_mem42", mem[8'h42], 32'hA5);
    chk("rm_mem43", mem[8'h43], 32'h5C);

    // back-to-back byte loads from 56 then 57, req held high throughout
    req = 1'b1; rw = 1'b0; size = 1'b0; addr = 8'd56; #1;
    chk("bb_t0_stall", stall, 1);
    tick();
    chk("bb_t1_addr",  ram_addr, 56);
    chk("bb_t1_e",     ram_e, 1);
    tick();
    chk("bb_t2_done",  done, 1);
    chk("bb_t2_rdata", rdata, 32'h0000_0009);
    addr = 8'd57;
    tick();
    chk("bb_t3_done",  done, 0);
    chk("bb_t3_stall", stall, 1);
    chk("bb_t3_rdata", rdata, 32'h0000_0009);
    tick();
    chk("bb_t4_addr",  ram_addr, 57);
    chk("bb_t4_done",  done, 0);
    tick();
    chk("bb_t5_done",  done, 1);
    chk("bb_t5_rdata", rdata, 32'h0000_0003);
    req = 1'b0;
    tick();
    chk("bb_t6_done",  done, 0);
    chk("bb_t6_stall", stall, 0);
    tick();
    chk("bb_t7_e",     ram_e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage controller between the EX/MEM pipeline register and the byte-wide 256×8 data RAM. It turns one load/store request (byte or word) into a sequence of single-byte RAM cycles. While the transfer is in progress it asserts a stall that freezes PC, IF/ID, ID/EX and EX/MEM. Read data is assembled big-endian and presented to the MEM/WB path for one cycle.

## Interface
Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 32, word width. Must be a multiple of 8. BYTES = DATA_W/8.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- R  in  1  reset. Synchronous, active-high.
- req  in  1  memory access request (MEM_Enable_signal).
- rw  in  1  1 = store, 0 = load (MEM_RW_enable).
- size  in  1  1 = word, 0 = byte (MEM_Size_enable).
- addr  in  ADDR_W  effective address from EX/MEM.
- wdata  in  DATA_W  store data (MEM_Pd).
- stall  out  1  freeze upstream stages and EX/MEM.
- done  out  1  one-cycle pulse: access complete.
- rdata  out  DATA_W  load result. Byte loads are zero-extended.
- ram_e  out  1  RAM enable.
- ram_rw  out  1  RAM direction (1 = write).
- ram_addr  out  ADDR_W  RAM byte address.
- ram_di  out  8  RAM write byte.
- ram_do  in  8  RAM read byte. The RAM read path is combinational.

## Operation
- States:
  - IDLE: no access in progress.
  - XFER: one byte transferred per cycle.
  - RESP: completion cycle; no RAM access.
- IDLE, req=1 at the edge:
  - Latch rw and size.
  - Latch base = size ? {addr[ADDR_W-1:2],2'b00} : addr. Word addresses are force-aligned, so addr[1:0] is ignored for word accesses.
  - Set last = size ? BYTES-1 : 0 and cnt = 0, then go to XFER.
- IDLE, req=0: stay in IDLE.
- XFER (combinational outputs):
  - ram_e=1, ram_rw=latched rw, ram_addr=base+cnt (ADDR_W-bit arithmetic).
  - Store: ram_di = word byte cnt, big-endian, so cnt=0 drives wdata[31:24]. Byte store drives wdata[7:0].
- XFER, at each edge:
  - Load: capture rdata ← {rdata[DATA_W-9:0], ram_do}. The shift register is cleared on XFER entry.
  - If cnt==last, go to RESP; otherwise cnt+1.
- RESP: done=1 and rdata valid; go to IDLE unconditionally. req is ignored in RESP because it still reflects the same instruction.
- Store rdata: holds 0.
- stall = (state==IDLE & req) | (state==XFER). stall is 0 in RESP, so the pipeline advances at the edge that ends RESP.
- Outside XFER: ram_e=0, ram_rw=0, ram_addr=0, ram_di=0.
- wdata and addr are sampled only in IDLE. Later input changes are ignored.

## Timing
- Reset (R=1 at an edge): state=IDLE, cnt=0, rdata=0, stall=0, done=0, all ram_* outputs 0. Reset overrides any request.
- Reset mid-transfer: the transfer aborts, and ram_e is 0 in the next cycle. Store bytes already written stay in RAM. No done pulse is issued.
- Byte access, with the request first seen in cycle T0:
  - T0: stall=1.
  - T1: XFER.
  - T2: RESP, done=1, stall=0.
  - Total: 2 stall cycles.
- Word access: stall is high in T0–T4, XFER runs in T1–T4, and RESP is T5. Total: 5 stall cycles.
- Back-to-back requests: the next instruction's req is first evaluated in the cycle after RESP. That cycle is its T0.
- Address wrap: cannot occur for word accesses, since base is aligned and base+3 ≤ 0xFF. Byte addresses are used as given.
- rdata is registered. It is stable from RESP until the next XFER entry.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, XFER, RESP}.
  - BYTES constant.
  - RW_READ/RW_WRITE and SIZE_BYTE/SIZE_WORD encodings.
- One sub-module, `mem_lane_shift`:
  - Read-assembly shift register with clear and shift-enable, DATA_W wide.
  - Write byte-lane selector.
- FSM and counter stay in the top module.

## Test plan
- Reset:
  - Stimulus: R=1 for 2 edges with req=1.
  - Required: stall=0, done=0, rdata=0, ram_e=0 throughout.
- Byte store:
  - Stimulus: req=1, rw=1, size=0, addr=58, wdata=0x0000005A.
  - Required: one ram_e cycle with ram_addr=58 and ram_di=0x5A; RAM[58]=0x5A; done in T2; 2 stall cycles.
- Word load:
  - Stimulus: RAM[52..55]=80,00,00,07; req=1, rw=0, size=1, addr=52.
  - Required: ram_addr sequence 52,53,54,55; rdata=0x80000007 with done in T5; stall high exactly 5 cycles.
- Misaligned word:
  - Stimulus: word store with addr=0x35, wdata=0xDEADBEEF.
  - Required: RAM[0x34..0x37]=DE,AD,BE,EF. A word load from 0x36 afterwards returns 0xDEADBEEF.
- Reset mid-transfer:
  - Stimulus: word store of 0x11223344 to 0x40; assert R after the second XFER cycle.
  - Required: RAM[0x40]=11 and RAM[0x41]=22; 0x42 and 0x43 unchanged; no done pulse; state=IDLE.
- Back-to-back:
  - Stimulus: byte load from 56 (value 0x09), then immediately a byte load from 57 (value 0x03).
  - Required: two done pulses 3 cycles apart; rdata 0x00000009 then 0x00000003; no request dropped or duplicated.
